// File: rtl/nx_indirect_access_seq.sv
// Host-side sequencer for the indirect register access block: turns one read/write
// request into data/command register writes, polls status, and returns a response.
module nx_indirect_access_seq #(
  parameter logic [10:0] CMND_ADDRESS   = 11'h454,
  parameter logic [10:0] STAT_ADDRESS   = 11'h44C,
  parameter logic [10:0] DATA_ADDRESS   = 11'h458,
  parameter int          N_ENTRIES      = 32,
  parameter logic [3:0]  OP_READ        = 4'h0,
  parameter logic [3:0]  OP_WRITE       = 4'h1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        _zzM132L132_bcMevClk0,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_index,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_stat,
  output logic        rsp_err,
  output logic        wr_stb,
  output logic [10:0] addr,
  output logic [31:0] wr_dat,
  output logic [3:0]  cmnd_op,
  output logic [4:0]  cmnd_addr,
  input  logic [2:0]  stat_code,
  input  logic [31:0] rd_dat,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_CMND,
    S_SETTLE,
    S_POLL,
    S_RDATA,
    S_RESP
  } state_t;

  localparam logic [2:0]  ST_RDY     = 3'h0;
  localparam logic [2:0]  ST_BSY     = 3'h1;
  localparam logic [2:0]  ST_TIMEOUT = 3'h2;
  localparam logic [2:0]  ST_BADIDX  = 3'h4;
  localparam logic [7:0]  TMO_LIMIT  = 8'(TIMEOUT_CYCLES);
  localparam logic [31:0] N_ENT_U    = N_ENTRIES;

  // Poll counter stops at the timeout limit so it can never wrap back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= TMO_LIMIT) ? c : c + 8'd1;
  endfunction

  function automatic logic [31:0] cmnd_word(input logic [4:0] idx, input logic [3:0] op);
    return {11'd0, idx, 12'd0, op};
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [4:0]  r_index;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nx;
  logic [7:0]  w_cnt_inc;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [2:0]  r_rsp_stat;
  logic        r_rsp_err;
  logic        r_wr_stb;
  logic [10:0] r_addr;
  logic [31:0] r_wr_dat;
  logic [3:0]  r_cmnd_op;
  logic [4:0]  r_cmnd_addr;
  logic        r_busy;

  logic [31:0] w_rsp_data_nx;
  logic [2:0]  w_rsp_stat_nx;
  logic [10:0] w_addr_nx;
  logic [31:0] w_wr_dat_nx;
  logic [3:0]  w_cmnd_op_nx;
  logic [4:0]  w_cmnd_addr_nx;

  logic        w_accept;
  logic        w_idx_bad;
  logic        w_cur_write;
  logic [4:0]  w_cur_index;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_op;

  assign w_accept  = req_valid && r_req_ready;
  assign w_idx_bad = ({27'd0, req_index} >= N_ENT_U);
  assign w_cnt_inc = sat_inc(r_cnt);

  // Outputs are decoded from the next state, so the request fields are used
  // directly on the accept edge and the latched copies afterwards.
  assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_cur_index = (r_state == S_IDLE) ? req_index : r_index;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_op    = w_cur_write ? OP_WRITE : OP_READ;

  always_ff @(posedge _zzM132L132_bcMevClk0) begin
    if (w_accept) begin
      r_write <= req_write;
      r_index <= req_index;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge _zzM132L132_bcMevClk0 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_nx      = r_cnt;
    w_rsp_data_nx = r_rsp_data;
    w_rsp_stat_nx = r_rsp_stat;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_idx_bad) begin
            w_next        = S_RESP;
            w_rsp_stat_nx = ST_BADIDX;
            w_rsp_data_nx = 32'd0;
          end else begin
            w_next = req_write ? S_WDATA : S_CMND;
          end
        end
      end
      S_WDATA:  w_next = S_CMND;
      S_CMND:   w_next = S_SETTLE;
      S_SETTLE: begin
        w_cnt_nx = 8'd0;
        w_next   = S_POLL;
      end
      S_POLL: begin
        if (stat_code == ST_BSY) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc >= TMO_LIMIT) begin
            w_next        = S_RESP;
            w_rsp_stat_nx = ST_TIMEOUT;
            w_rsp_data_nx = 32'd0;
          end
        end else if (stat_code == ST_RDY) begin
          if (r_write) begin
            w_next        = S_RESP;
            w_rsp_stat_nx = ST_RDY;
            w_rsp_data_nx = 32'd0;
          end else begin
            w_next = S_RDATA;
          end
        end else begin
          w_next        = S_RESP;
          w_rsp_stat_nx = stat_code;
          w_rsp_data_nx = 32'd0;
        end
      end
      S_RDATA: begin
        w_next        = S_RESP;
        w_rsp_data_nx = rd_dat;
        w_rsp_stat_nx = ST_RDY;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next        = S_IDLE;
          w_rsp_data_nx = 32'd0;
          w_rsp_stat_nx = ST_RDY;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Register-bus drive for the state about to be entered.
  always_comb begin
    w_addr_nx      = STAT_ADDRESS;
    w_wr_dat_nx    = 32'd0;
    w_cmnd_op_nx   = 4'd0;
    w_cmnd_addr_nx = 5'd0;
    case (w_next)
      S_WDATA: begin
        w_addr_nx   = DATA_ADDRESS;
        w_wr_dat_nx = w_cur_wdata;
      end
      S_CMND: begin
        w_addr_nx      = CMND_ADDRESS;
        w_cmnd_op_nx   = w_cur_op;
        w_cmnd_addr_nx = w_cur_index;
        w_wr_dat_nx    = cmnd_word(w_cur_index, w_cur_op);
      end
      S_RDATA: w_addr_nx = DATA_ADDRESS;
      default: w_addr_nx = STAT_ADDRESS;
    endcase
  end

  always_ff @(posedge _zzM132L132_bcMevClk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_stat  <= ST_RDY;
      r_rsp_err   <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_addr      <= STAT_ADDRESS;
      r_wr_dat    <= 32'd0;
      r_cmnd_op   <= 4'd0;
      r_cmnd_addr <= 5'd0;
      r_busy      <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_req_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_stat  <= w_rsp_stat_nx;
      r_rsp_err   <= (w_rsp_stat_nx != ST_RDY);
      r_wr_stb    <= (w_next == S_WDATA) || (w_next == S_CMND);
      r_addr      <= w_addr_nx;
      r_wr_dat    <= w_wr_dat_nx;
      r_cmnd_op   <= w_cmnd_op_nx;
      r_cmnd_addr <= w_cmnd_addr_nx;
      r_cnt       <= w_cnt_nx;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_stat  = r_rsp_stat;
  assign rsp_err   = r_rsp_err;
  assign wr_stb    = r_wr_stb;
  assign addr      = r_addr;
  assign wr_dat    = r_wr_dat;
  assign cmnd_op   = r_cmnd_op;
  assign cmnd_addr = r_cmnd_addr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nx_indirect_access_seq.sv
// Bench for nx_indirect_access_seq: a timeline model derived from the latency rules
// is compared against the outputs every cycle, plus literal checks per scenario.
module tb_nx_indirect_access_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_index = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic [2:0]  stat_code = 3'h1;
  logic [31:0] rd_dat;

  logic        u1_req_ready, u1_rsp_valid, u1_rsp_err, u1_wr_stb, u1_busy;
  logic [31:0] u1_rsp_data, u1_wr_dat;
  logic [2:0]  u1_rsp_stat;
  logic [10:0] u1_addr;
  logic [3:0]  u1_cmnd_op;
  logic [4:0]  u1_cmnd_addr;
  logic        u2_req_ready, u2_rsp_valid, u2_rsp_err, u2_wr_stb, u2_busy;
  logic [31:0] u2_rsp_data, u2_wr_dat;
  logic [2:0]  u2_rsp_stat;
  logic [10:0] u2_addr;
  logic [3:0]  u2_cmnd_op;
  logic [4:0]  u2_cmnd_addr;

  nx_indirect_access_seq dut (
    ._zzM132L132_bcMevClk0(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(u1_req_ready), .req_write(req_write),
    .req_index(req_index), .req_wdata(req_wdata),
    .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(u1_rsp_data),
    .rsp_stat(u1_rsp_stat), .rsp_err(u1_rsp_err),
    .wr_stb(u1_wr_stb), .addr(u1_addr), .wr_dat(u1_wr_dat),
    .cmnd_op(u1_cmnd_op), .cmnd_addr(u1_cmnd_addr),
    .stat_code(stat_code), .rd_dat(rd_dat), .busy(u1_busy)
  );

  nx_indirect_access_seq #(.N_ENTRIES(16)) dut16 (
    ._zzM132L132_bcMevClk0(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(u2_req_ready), .req_write(req_write),
    .req_index(req_index), .req_wdata(req_wdata),
    .rsp_valid(u2_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(u2_rsp_data),
    .rsp_stat(u2_rsp_stat), .rsp_err(u2_rsp_err),
    .wr_stb(u2_wr_stb), .addr(u2_addr), .wr_dat(u2_wr_dat),
    .cmnd_op(u2_cmnd_op), .cmnd_addr(u2_cmnd_addr),
    .stat_code(stat_code), .rd_dat(rd_dat), .busy(u2_busy)
  );

  // Selected device under observation.
  logic sel = 1'b0;
  wire        m_req_ready = sel ? u2_req_ready : u1_req_ready;
  wire        m_rsp_valid = sel ? u2_rsp_valid : u1_rsp_valid;
  wire [31:0] m_rsp_data  = sel ? u2_rsp_data  : u1_rsp_data;
  wire [2:0]  m_rsp_stat  = sel ? u2_rsp_stat  : u1_rsp_stat;
  wire        m_rsp_err   = sel ? u2_rsp_err   : u1_rsp_err;
  wire        m_wr_stb    = sel ? u2_wr_stb    : u1_wr_stb;
  wire [10:0] m_addr      = sel ? u2_addr      : u1_addr;
  wire [31:0] m_wr_dat    = sel ? u2_wr_dat    : u1_wr_dat;
  wire [3:0]  m_cmnd_op   = sel ? u2_cmnd_op   : u1_cmnd_op;
  wire [4:0]  m_cmnd_addr = sel ? u2_cmnd_addr : u1_cmnd_addr;
  wire        m_busy      = sel ? u2_busy      : u1_busy;

  // Downstream data register returns the table value only when DATA is addressed.
  logic [31:0] t_rd = 32'd0;
  assign rd_dat = (u1_addr == 11'h458) ? t_rd : 32'h0BAD_F00D;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Transaction description for the model.
  bit          t_write = 1'b0;
  bit          t_bad = 1'b0;
  logic [4:0]  t_index = 5'd0;
  logic [31:0] t_wdata = 32'd0;
  int          t_nb = 0;
  logic [2:0]  t_fc = 3'h0;
  int          t_hold = 0;
  bit          txn_on = 1'b0;
  bit          chk_on = 1'b0;
  int          k = 0;

  function automatic int p0();
    return t_write ? 4 : 3;
  endfunction
  function automatic bit tmo();
    return !t_bad && (t_nb >= 255);
  endfunction
  function automatic int npoll();
    return tmo() ? 255 : t_nb + 1;
  endfunction
  function automatic logic [2:0] fin();
    if (t_bad) return 3'h4;
    if (tmo()) return 3'h2;
    return t_fc;
  endfunction
  function automatic int rstart();
    if (t_bad) return 1;
    return p0() + npoll() + ((!t_write && fin() == 3'h0) ? 1 : 0);
  endfunction
  function automatic logic [31:0] edata();
    return (!t_write && fin() == 3'h0) ? t_rd : 32'd0;
  endfunction
  function automatic logic [2:0] mstat(input int kk);
    if (!t_bad && kk >= p0() && kk < p0() + npoll())
      return (kk - p0() < t_nb) ? 3'h1 : t_fc;
    return 3'h1;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      int r;
      bit act, rv, dwr, cmd, rdp;
      logic [10:0] ea;
      logic [3:0]  eop;
      r   = rstart();
      act = txn_on && (k >= 1) && (k <= r + t_hold);
      rv  = act && (k >= r);
      dwr = act && !t_bad && t_write && (k == 1);
      cmd = act && !t_bad && (k == (t_write ? 2 : 1));
      rdp = act && !t_bad && !t_write && (fin() == 3'h0) && (k == r - 1);
      ea  = cmd ? 11'h454 : ((dwr || rdp) ? 11'h458 : 11'h44C);
      eop = t_write ? 4'h1 : 4'h0;
      chk("req_ready", 32'(m_req_ready), 32'(!act));
      chk("busy", 32'(m_busy), 32'(act));
      chk("rsp_valid", 32'(m_rsp_valid), 32'(rv));
      chk("wr_stb", 32'(m_wr_stb), 32'(dwr || cmd));
      chk("addr", 32'(m_addr), 32'(ea));
      if (dwr) chk("wr_dat_data", m_wr_dat, t_wdata);
      if (cmd) begin
        chk("wr_dat_cmnd", m_wr_dat, {11'd0, t_index, 12'd0, eop});
        chk("cmnd_op", 32'(m_cmnd_op), 32'(eop));
        chk("cmnd_addr", 32'(m_cmnd_addr), 32'(t_index));
      end
      if (rv) begin
        chk("rsp_data", m_rsp_data, edata());
        chk("rsp_stat", 32'(m_rsp_stat), 32'(fin()));
        chk("rsp_err", 32'(m_rsp_err), 32'(fin() != 3'h0));
      end
    end
  end

  int          first_rsp;
  int          stb_count;
  logic [31:0] snap_data;
  logic [2:0]  snap_stat;
  logic [10:0] sn_addr [1:2];
  logic [31:0] sn_wdat [1:2];
  logic [3:0]  sn_op   [1:2];
  logic [4:0]  sn_cadr [1:2];

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(u1_req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(u1_rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, u1_rsp_data, 32'd0);
    chk({tag, "_rsp_stat"}, 32'(u1_rsp_stat), 32'd0);
    chk({tag, "_rsp_err"}, 32'(u1_rsp_err), 32'd0);
    chk({tag, "_wr_stb"}, 32'(u1_wr_stb), 32'd0);
    chk({tag, "_addr"}, 32'(u1_addr), 32'h44C);
    chk({tag, "_wr_dat"}, u1_wr_dat, 32'd0);
    chk({tag, "_cmnd_op"}, 32'(u1_cmnd_op), 32'd0);
    chk({tag, "_cmnd_addr"}, 32'(u1_cmnd_addr), 32'd0);
    chk({tag, "_busy"}, 32'(u1_busy), 32'd0);
  endtask

  // Drives one request and the downstream status responses; every loop is
  // bounded by the model's own response time, never by a DUT event.
  task automatic run_txn(input bit s, input bit w, input logic [4:0] idx,
                         input logic [31:0] wd, input int nb, input logic [2:0] fc,
                         input logic [31:0] rdv, input int hold, input int abort_at);
    sel = s; t_write = w; t_index = idx; t_wdata = wd; t_nb = nb; t_fc = fc;
    t_rd = rdv; t_hold = hold;
    t_bad = (int'(idx) >= (s ? 16 : 32));
    req_write = w; req_index = idx; req_wdata = wd;
    k = 0; first_rsp = -1; stb_count = 0;
    txn_on = 1'b1;
    if (s) req_valid2 = 1'b1;
    else   req_valid  = 1'b1;
    while (k <= rstart() + t_hold) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid2 = 1'b0;
      k++;
      if (k == abort_at) begin
        txn_on = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        stat_code = 3'h1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        return;
      end
      stat_code = mstat(k);
      rsp_ready = (k == rstart() + t_hold);
      if (m_wr_stb) stb_count++;
      if (first_rsp < 0 && m_rsp_valid) begin
        first_rsp = k; snap_data = m_rsp_data; snap_stat = m_rsp_stat;
      end
      if (k == 1 || k == 2) begin
        sn_addr[k] = m_addr; sn_wdat[k] = m_wr_dat;
        sn_op[k] = m_cmnd_op; sn_cadr[k] = m_cmnd_addr;
      end
    end
    rsp_ready = 1'b0;
    stat_code = 3'h1;
    txn_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Write, ready on first poll.
    run_txn(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, 3'h0, 32'd0, 0, -1);
    chk("w_first_rsp", 32'(first_rsp), 32'd5);
    chk("w_addr_t1", 32'(sn_addr[1]), 32'h458);
    chk("w_wdat_t1", sn_wdat[1], 32'hDEAD_BEEF);
    chk("w_addr_t2", 32'(sn_addr[2]), 32'h454);
    chk("w_op_t2", 32'(sn_op[2]), 32'd1);
    chk("w_cadr_t2", 32'(sn_cadr[2]), 32'd5);
    chk("w_wdat_t2", sn_wdat[2], 32'h0005_0001);
    chk("w_stat", 32'(snap_stat), 32'd0);
    chk("w_data", snap_data, 32'd0);

    // Read index 31, three busy polls.
    run_txn(1'b0, 1'b0, 5'd31, 32'd0, 3, 3'h0, 32'h1234_5678, 1, -1);
    chk("r_first_rsp", 32'(first_rsp), 32'd8);
    chk("r_data", snap_data, 32'h1234_5678);
    chk("r_addr_t1", 32'(sn_addr[1]), 32'h454);
    chk("r_wdat_t1", sn_wdat[1], 32'h001F_0000);

    // Status stuck busy: 255 polls after cmnd(T+1), settle(T+2).
    run_txn(1'b0, 1'b0, 5'd2, 32'd0, 1000, 3'h0, 32'h7777_7777, 2, -1);
    chk("tmo_first_rsp", 32'(first_rsp), 32'd258);
    chk("tmo_stat", 32'(snap_stat), 32'd2);
    chk("tmo_data", snap_data, 32'd0);

    // Out-of-range index on the 16-entry instance.
    run_txn(1'b1, 1'b0, 5'd31, 32'd0, 0, 3'h0, 32'd0, 1, -1);
    chk("bad_first_rsp", 32'(first_rsp), 32'd1);
    chk("bad_stat", 32'(snap_stat), 32'd4);
    chk("bad_stb_count", 32'(stb_count), 32'd0);

    // Error code on first poll, response held for 10 cycles.
    run_txn(1'b0, 1'b1, 5'd9, 32'h0000_0055, 0, 3'h3, 32'd0, 10, -1);
    chk("err_first_rsp", 32'(first_rsp), 32'd5);
    chk("err_stat", 32'(snap_stat), 32'd3);
    chk("err_data", snap_data, 32'd0);

    // Write with two busy polls.
    run_txn(1'b0, 1'b1, 5'd0, 32'hA5A5_A5A5, 2, 3'h0, 32'd0, 0, -1);
    chk("w2_first_rsp", 32'(first_rsp), 32'd7);

    // Reset while polling, then a clean read.
    run_txn(1'b0, 1'b0, 5'd3, 32'd0, 1000, 3'h0, 32'd0, 0, 5);
    run_txn(1'b0, 1'b0, 5'd7, 32'd0, 0, 3'h0, 32'hCAFE_F00D, 0, -1);
    chk("post_rst_first_rsp", 32'(first_rsp), 32'd5);
    chk("post_rst_data", snap_data, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_indirect_access_seq.md
Name: nx_indirect_access_seq

Overview:
Host-side command sequencer that sits directly upstream of the indirect register access block. It accepts single-entry read/write requests on a valid/ready interface and issues the corresponding register-bus traffic: a data write, then a command write. It then polls the status code until the access completes and returns read data or an error status on a response handshake. This removes CSR polling from firmware/testbench and serialises all accesses to one indirect table.

Parameters:
CMND_ADDRESS, 11'h454, register address of the indirect command register
STAT_ADDRESS, 11'h44C, register address of the indirect status register
DATA_ADDRESS, 11'h458, register address of the indirect data register
N_ENTRIES, 32, number of table entries; legal indices 0..N_ENTRIES-1
OP_READ, 4'h0, cmnd_op encoding for read
OP_WRITE, 4'h1, cmnd_op encoding for write
TIMEOUT_CYCLES, 255, maximum number of poll cycles before a timeout error

Ports:
_zzM132L132_bcMevClk0  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer can accept a request
req_write  in  1  1=write, 0=read
req_index  in  5  table entry index
req_wdata  in  32  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  32  read data; 0 for writes and errors
rsp_stat  out  3  final status code (0=RDY; otherwise error code)
rsp_err  out  1  rsp_stat != 0
wr_stb  out  1  register-bus write strobe to the indirect access block
addr  out  11  register-bus address
wr_dat  out  32  register-bus write data
cmnd_op  out  4  command opcode, valid with wr_stb at CMND_ADDRESS
cmnd_addr  out  5  command entry index
stat_code  in  3  status from the indirect access block: 0=RDY, 1=BSY, others=error
rd_dat  in  32  register read data for the current addr, combinational from the downstream block
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_stat=0, rsp_err=0.
  - wr_stb=0, addr=STAT_ADDRESS, wr_dat=0, cmnd_op=0, cmnd_addr=0, busy=0, poll counter=0.
  - Reset mid-operation aborts immediately. No response is generated.
- All outputs are registered.
- States: IDLE, WDATA, CMND, SETTLE, POLL, RDATA, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid && req_ready (cycle T); latch write, index, wdata.
  - index >= N_ENTRIES: go to RESP with rsp_stat=3'h4, data=0. No bus activity.
  - Otherwise a write goes to WDATA and a read goes to CMND.
- WDATA (one cycle): wr_stb=1, addr=DATA_ADDRESS, wr_dat=latched wdata → CMND.
- CMND (one cycle):
  - wr_stb=1, addr=CMND_ADDRESS, cmnd_op=OP_WRITE/OP_READ, cmnd_addr=index.
  - wr_dat={cmnd_addr zero-extended to 16 bits, 12'b0, cmnd_op}.
  - Next state SETTLE.
- SETTLE (one cycle): wr_stb=0, addr=STAT_ADDRESS; clear poll counter → POLL.
- POLL: addr=STAT_ADDRESS; stat_code is sampled every cycle.
  - BSY: increment counter. If counter reaches TIMEOUT_CYCLES, go to RESP with rsp_stat=3'h2.
  - RDY: a read goes to RDATA; a write goes to RESP with stat=0.
  - Any other code: go to RESP with rsp_stat=stat_code, data=0.
- RDATA (one cycle): addr=DATA_ADDRESS; capture rd_dat into rsp_data at cycle end → RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_stat and rsp_err are held stable until rsp_ready.
  - The cycle rsp_valid && rsp_ready is seen, go to IDLE and clear rsp_valid.
  - req_ready=0 in every non-IDLE state; requests do not pipeline.
- Latency, request accept at cycle T with stat_code RDY on the first poll:
  - Write: wr_stb at T+1 (data) and T+2 (cmnd); first POLL at T+4; rsp_valid at T+5.
  - Read: cmnd at T+1; POLL at T+3; RDATA at T+4; rsp_valid at T+5.
- The poll counter is 8-bit and saturates at TIMEOUT_CYCLES; it never wraps.
- A request presented while not IDLE is held off by req_ready=0. The host must hold req_valid and its fields stable.

Test Plan:
- Write index 5, data 32'hDEAD_BEEF, stat_code RDY immediately → wr_stb at T+1 (addr 11'h458, data DEADBEEF) and T+2 (addr 11'h454, cmnd_op 1, cmnd_addr 5); rsp_valid at T+5, rsp_stat 0, rsp_data 0.
- Read index 31, stat_code BSY for 3 poll cycles then RDY, rd_dat 32'h1234_5678 when addr=11'h458 → rsp_valid at T+8, rsp_data 32'h12345678, rsp_err 0.
- stat_code held at BSY → exactly 255 poll cycles, then rsp_stat 3'h2, rsp_err 1; return to IDLE after rsp_ready.
- req_index 5'd31 with N_ENTRIES=16 → no wr_stb ever asserted; rsp_valid at T+1 with rsp_stat 3'h4.
- stat_code 3'h3 on the first poll → rsp_stat 3'h3, rsp_err 1, rsp_data 0; rsp_ready held low 10 cycles → outputs stable throughout, req_ready stays 0.
- rst_n asserted during POLL → all outputs return to reset values asynchronously; after release a new read completes normally.
